// File: rtl/sram_arbiter_pkg.sv
// Shared encodings and helpers for the two-master SRAM arbiter.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// One requester port: level-held rd/wr enable with a one-cycle ready pulse back.
// Latency: none (wires only).
// Backpressure: the requester holds its enable until ready pulses.
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output rd_en, wr_en, addr, wdata, input rdata, ready);
  modport slave  (input rd_en, wr_en, addr, wdata, output rdata, ready);
endinterface

// File: rtl/sram_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the master that did not win last.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is used.
module rr_arbiter2
  import sram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_id,
  output logic       grant_vld
);

  // Lone requester wins; on a tie the other master from last time wins.
  always_comb begin
    grant_vld = |req;
    grant_id  = M0;
    if (req == 2'b11) begin
      grant_id = ~last_grant;
    end else if (req[1]) begin
      grant_id = M1;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller port between two masters (round-robin on ties); perf counters under SRAM_ARB_PERF_EN.
// Latency: SRAM enable from the cycle after the request is sampled; m*_ready the cycle after sram_ready (3 cycles min).
// Backpressure: requests stay level-held until m*_ready; inputs are ignored while an access is in flight.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  sram_arbiter_if.slave     m0,
  sram_arbiter_if.slave     m1,
  output logic              sram_readEn,
  output logic              sram_writeEn,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_writeData,
  input  logic [DATA_W-1:0] sram_readData,
  input  logic              sram_ready,
  output logic              owner
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_grants0,
  output logic [31:0]       perf_grants1,
  output logic [31:0]       perf_conflicts
`endif
);

  state_t            state;
  logic              last_grant;
  logic [1:0]        req;
  logic              gnt_id;
  logic              gnt_vld;
  op_t               sel_op;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req = {m1.rd_en | m1.wr_en, m0.rd_en | m0.wr_en};

  rr_arbiter2 u_rr (
    .req        (req),
    .last_grant (last_grant),
    .grant_id   (gnt_id),
    .grant_vld  (gnt_vld)
  );

  // Pick the winner's command; write takes priority when both enables are high.
  always_comb begin
    sel_addr  = m0.addr;
    sel_wdata = m0.wdata;
    sel_op    = m0.wr_en ? OP_WR : OP_RD;
    if (gnt_id == M1) begin
      sel_addr  = m1.addr;
      sel_wdata = m1.wdata;
      sel_op    = m1.wr_en ? OP_WR : OP_RD;
    end
  end

  // Arbitration FSM: latch the winning command, hold it for the access, pulse the owner's ready once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      last_grant     <= M1;
      owner          <= M0;
      sram_readEn    <= 1'b0;
      sram_writeEn   <= 1'b0;
      sram_address   <= '0;
      sram_writeData <= '0;
      m0.rdata       <= '0;
      m0.ready       <= 1'b0;
      m1.rdata       <= '0;
      m1.ready       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            sram_address   <= sel_addr;
            sram_writeData <= sel_wdata;
            sram_writeEn   <= (sel_op == OP_WR);
            sram_readEn    <= (sel_op == OP_RD);
            owner          <= gnt_id;
            last_grant     <= gnt_id;
            state          <= BUSY;
          end
        end
        BUSY: begin
          if (sram_ready) begin
            if (owner == M1) begin
              m1.rdata <= sram_readData;
              m1.ready <= 1'b1;
            end else begin
              m0.rdata <= sram_readData;
              m0.ready <= 1'b1;
            end
            sram_readEn  <= 1'b0;
            sram_writeEn <= 1'b0;
            state        <= RELEASE;
          end
        end
        RELEASE: begin
          m0.ready <= 1'b0;
          m1.ready <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SRAM_ARB_PERF_EN
  // Saturating counts of grants per master and of contested idle cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_grants0   <= '0;
      perf_grants1   <= '0;
      perf_conflicts <= '0;
    end else if (state == IDLE) begin
      if (gnt_vld && gnt_id == M0) perf_grants0 <= sat_inc(perf_grants0);
      if (gnt_vld && gnt_id == M1) perf_grants1 <= sat_inc(perf_grants1);
      if (req == 2'b11)            perf_conflicts <= sat_inc(perf_conflicts);
    end
  end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed steps, per-master scoreboards, a simple SRAM responder.
// Latency: responder raises sram_ready after a programmable number of enable cycles.
// Backpressure: each master driver holds its request until that master's ready pulse.
module tb_sram_arbiter;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] chg;
  } req_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        sram_readEn;
  logic        sram_writeEn;
  logic [31:0] sram_address;
  logic [31:0] sram_writeData;
  logic [31:0] sram_readData;
  logic        sram_ready;
  logic        owner;
`ifdef SRAM_ARB_PERF_EN
  logic [31:0] perf_grants0;
  logic [31:0] perf_grants1;
  logic [31:0] perf_conflicts;
`endif

  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();

  sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .m0             (m0_if),
    .m1             (m1_if),
    .sram_readEn    (sram_readEn),
    .sram_writeEn   (sram_writeEn),
    .sram_address   (sram_address),
    .sram_writeData (sram_writeData),
    .sram_readData  (sram_readData),
    .sram_ready     (sram_ready),
    .owner          (owner)
`ifdef SRAM_ARB_PERF_EN
    ,
    .perf_grants0   (perf_grants0),
    .perf_grants1   (perf_grants1),
    .perf_conflicts (perf_conflicts)
`endif
  );

  int   n_cmp = 0;
  int   n_err = 0;
  int   sram_lat = 1;
  req_t d0_q[$];
  req_t d1_q[$];
  exp_t exp0[$];
  exp_t exp1[$];
  bit   exp_grants[$];
  bit   obs_grants[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] sram_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic issue(input bit m, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] chg);
    req_t r;
    exp_t e;
    r = '{rd: rd, wr: wr, addr: a, wdata: wd, chg: chg};
    e = '{addr: a, wr: wr, wdata: wd, rdata: sram_val(a)};
    if (m) begin
      d1_q.push_back(r);
      exp1.push_back(e);
    end else begin
      d0_q.push_back(r);
      exp0.push_back(e);
    end
  endtask

  task automatic check_cmd(input string tag, input exp_t e);
    check({tag, "_addr"}, sram_address, e.addr);
    check({tag, "_wen"}, {31'd0, sram_writeEn}, {31'd0, e.wr});
    check({tag, "_ren"}, {31'd0, sram_readEn}, {31'd0, !e.wr});
    if (e.wr) check({tag, "_wdata"}, sram_writeData, e.wdata);
  endtask

  task automatic check_grants(input string tag);
    check({tag, "_ngrants"}, obs_grants.size(), exp_grants.size());
    for (int i = 0; i < exp_grants.size() && i < obs_grants.size(); i++)
      check({tag, "_grant_order"}, {31'd0, obs_grants[i]}, {31'd0, exp_grants[i]});
    obs_grants.delete();
    exp_grants.delete();
  endtask

  task automatic wait_done(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = (d0_q.size() == 0 && d1_q.size() == 0 && exp0.size() == 0 && exp1.size() == 0);
    end
    check({tag, "_drained"}, {31'd0, done}, 32'd1);
    @(negedge clk);
  endtask

  // Master 0 driver: hold the head request until ready, optionally move the address mid-access.
  initial begin
    int age;
    bit busy;
    busy = 1'b0;
    age = 0;
    m0_if.rd_en = 1'b0; m0_if.wr_en = 1'b0; m0_if.addr = '0; m0_if.wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        d0_q.delete(); busy = 1'b0;
        m0_if.rd_en = 1'b0; m0_if.wr_en = 1'b0; m0_if.addr = '0; m0_if.wdata = '0;
      end else begin
        if (busy) begin
          age++;
          if (m0_if.ready) begin
            void'(d0_q.pop_front());
            busy = 1'b0;
            m0_if.rd_en = 1'b0; m0_if.wr_en = 1'b0;
          end else if (age == 2 && d0_q[0].chg != 0) begin
            m0_if.addr = d0_q[0].chg;
          end
        end
        if (!busy && d0_q.size() > 0) begin
          m0_if.rd_en = d0_q[0].rd; m0_if.wr_en = d0_q[0].wr;
          m0_if.addr = d0_q[0].addr; m0_if.wdata = d0_q[0].wdata;
          busy = 1'b1; age = 0;
        end
      end
    end
  end

  // Master 1 driver: same behaviour as master 0.
  initial begin
    int age;
    bit busy;
    busy = 1'b0;
    age = 0;
    m1_if.rd_en = 1'b0; m1_if.wr_en = 1'b0; m1_if.addr = '0; m1_if.wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        d1_q.delete(); busy = 1'b0;
        m1_if.rd_en = 1'b0; m1_if.wr_en = 1'b0; m1_if.addr = '0; m1_if.wdata = '0;
      end else begin
        if (busy) begin
          age++;
          if (m1_if.ready) begin
            void'(d1_q.pop_front());
            busy = 1'b0;
            m1_if.rd_en = 1'b0; m1_if.wr_en = 1'b0;
          end else if (age == 2 && d1_q[0].chg != 0) begin
            m1_if.addr = d1_q[0].chg;
          end
        end
        if (!busy && d1_q.size() > 0) begin
          m1_if.rd_en = d1_q[0].rd; m1_if.wr_en = d1_q[0].wr;
          m1_if.addr = d1_q[0].addr; m1_if.wdata = d1_q[0].wdata;
          busy = 1'b1; age = 0;
        end
      end
    end
  end

  // SRAM responder: ready for one cycle after sram_lat enabled cycles.
  initial begin
    int mcnt;
    mcnt = 0;
    sram_ready = 1'b0;
    sram_readData = '0;
    forever begin
      @(negedge clk);
      if (!rst || sram_ready) begin
        sram_ready = 1'b0;
        mcnt = 0;
      end else if (sram_readEn || sram_writeEn) begin
        mcnt++;
        if (mcnt >= sram_lat) begin
          sram_ready = 1'b1;
          sram_readData = sram_val(sram_address);
        end
      end
    end
  end

  // Monitor: check each command as it is issued and each completion against the scoreboards.
  initial begin
    bit prev_en;
    bit cur_owner;
    exp_t e;
    prev_en = 1'b0;
    cur_owner = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_en = 1'b0;
      end else begin
        if ((sram_readEn || sram_writeEn) && !prev_en) begin
          cur_owner = owner;
          obs_grants.push_back(owner);
          if (owner) begin
            check("cmd1_pending", {31'd0, exp1.size() != 0}, 32'd1);
            if (exp1.size() != 0) check_cmd("cmd1", exp1[0]);
          end else begin
            check("cmd0_pending", {31'd0, exp0.size() != 0}, 32'd1);
            if (exp0.size() != 0) check_cmd("cmd0", exp0[0]);
          end
        end
        prev_en = sram_readEn || sram_writeEn;
        if (m0_if.ready || m1_if.ready) begin
          check("ready_exclusive", {31'd0, m0_if.ready && m1_if.ready}, 32'd0);
          check("ready_owner", {31'd0, m1_if.ready}, {31'd0, cur_owner});
        end
        if (m0_if.ready) begin
          check("rdy0_pending", {31'd0, exp0.size() != 0}, 32'd1);
          if (exp0.size() != 0) begin
            e = exp0.pop_front();
            if (!e.wr) check("rdata0", m0_if.rdata, e.rdata);
          end
        end
        if (m1_if.ready) begin
          check("rdy1_pending", {31'd0, exp1.size() != 0}, 32'd1);
          if (exp1.size() != 0) begin
            e = exp1.pop_front();
            if (!e.wr) check("rdata1", m1_if.rdata, e.rdata);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Single master-0 read of 0x100 with a 3-cycle SRAM, cycle-accurate checks.
  task automatic single_read(input string tag, input logic [31:0] chg);
    int en_cnt, rdy_cnt, rdy_k, m1_cnt;
    en_cnt = 0; rdy_cnt = 0; rdy_k = -1; m1_cnt = 0;
    sram_lat = 3;
    @(posedge clk); #1;
    issue(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, chg);
    exp_grants.push_back(1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (sram_readEn) begin
        en_cnt++;
        check({tag, "_addr_busy"}, sram_address, 32'h100);
      end
      if (m0_if.ready) begin
        rdy_cnt++;
        rdy_k = k;
        check({tag, "_addr_release"}, sram_address, 32'h100);
      end
      if (m1_if.ready) m1_cnt++;
    end
    check({tag, "_readEn_cycles"}, en_cnt, 32'd3);
    check({tag, "_ready_pulses"}, rdy_cnt, 32'd1);
    check({tag, "_ready_cycle"}, rdy_k, 32'd4);
    check({tag, "_m1_ready_pulses"}, m1_cnt, 32'd0);
    check({tag, "_rdata_held"}, m0_if.rdata, 32'hDEAD_BEEF);
    wait_done(tag);
    check_grants(tag);
    sram_lat = 1;
  endtask

  initial begin
    int rd_cnt, wr_cnt;
    bit seen;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_readEn", {31'd0, sram_readEn}, 32'd0);
    check("rst_writeEn", {31'd0, sram_writeEn}, 32'd0);
    check("rst_address", sram_address, 32'd0);
    check("rst_writeData", sram_writeData, 32'd0);
    check("rst_m0_rdata", m0_if.rdata, 32'd0);
    check("rst_m1_rdata", m1_if.rdata, 32'd0);
    check("rst_readies", {30'd0, m1_if.ready, m0_if.ready}, 32'd0);
    check("rst_owner", {31'd0, owner}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;

    // Both masters keep requesting: first tie to m0, then strict alternation.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 1'b1, 1'b0, 32'h10 + 32'(4 * i), 32'h0, 32'h0);
      issue(1'b1, 1'b0, 1'b1, 32'h20 + 32'(4 * i), 32'h55 + 32'(i), 32'h0);
      exp_grants.push_back(1'b0);
      exp_grants.push_back(1'b1);
    end
    wait_done("alternate");
    check_grants("alternate");

    single_read("single", 32'h0);
    single_read("addr_change", 32'h200);

    // Both rd_en and wr_en from m1: a write is issued, readEn never rises.
    sram_lat = 2;
    rd_cnt = 0; wr_cnt = 0;
    @(posedge clk); #1;
    issue(1'b1, 1'b1, 1'b1, 32'h40, 32'h77, 32'h0);
    exp_grants.push_back(1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (sram_readEn) rd_cnt++;
      if (sram_writeEn) wr_cnt++;
    end
    check("rdwr_readEn_cycles", rd_cnt, 32'd0);
    check("rdwr_writeEn_cycles", wr_cnt, 32'd2);
    wait_done("rdwr");
    check_grants("rdwr");

    // Reset in the middle of a long access.
    sram_lat = 6;
    seen = 1'b0;
    @(posedge clk); #1;
    issue(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 32'h0);
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = sram_readEn;
    end
    check("midrst_access_started", {31'd0, seen}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("midrst_readEn", {31'd0, sram_readEn}, 32'd0);
    check("midrst_writeEn", {31'd0, sram_writeEn}, 32'd0);
    check("midrst_readies", {30'd0, m1_if.ready, m0_if.ready}, 32'd0);
    exp0.delete(); exp1.delete(); exp_grants.delete(); obs_grants.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    sram_lat = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("midrst_no_stale_ready", {30'd0, m1_if.ready, m0_if.ready}, 32'd0);
    end

    // Two ties and one lone m0 request after reset.
    @(posedge clk); #1;
    issue(1'b0, 1'b1, 1'b0, 32'h50, 32'h0, 32'h0);
    issue(1'b1, 1'b1, 1'b0, 32'h60, 32'h0, 32'h0);
    exp_grants.push_back(1'b0); exp_grants.push_back(1'b1);
    wait_done("tie1");
    @(posedge clk); #1;
    issue(1'b0, 1'b1, 1'b0, 32'h54, 32'h0, 32'h0);
    issue(1'b1, 1'b1, 1'b0, 32'h64, 32'h0, 32'h0);
    exp_grants.push_back(1'b0); exp_grants.push_back(1'b1);
    wait_done("tie2");
    @(posedge clk); #1;
    issue(1'b0, 1'b1, 1'b0, 32'h58, 32'h0, 32'h0);
    exp_grants.push_back(1'b0);
    wait_done("solo");
    check_grants("after_reset");
`ifdef SRAM_ARB_PERF_EN
    check("perf_grants0", perf_grants0, 32'd3);
    check("perf_grants1", perf_grants1, 32'd2);
    check("perf_conflicts", perf_conflicts, 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
